// File: rtl/dsp_pkg.sv
// Shared DSP helpers for the multiplier/decimator family: rounding, saturation, shared types.
package dsp_pkg;

    localparam int DSP_SHIFT_W = 6;

    typedef enum logic {
        IQ_IDLE = 1'b0,
        IQ_ACC  = 1'b1
    } iq_state_e;

    // Arithmetic shift right by sh, then round half away from zero.
    function automatic logic signed [63:0] dsp_round_haz(
        input logic signed [63:0]      x,
        input logic [DSP_SHIFT_W-1:0]  sh
    );
        logic signed [63:0] t;
        logic [63:0]        lo_mask;
        logic               guard;
        logic               sticky;
        logic               inc;
        if (sh == '0) return x;
        t       = x >>> sh;
        guard   = x[sh - 6'd1];
        lo_mask = (64'd1 << (sh - 6'd1)) - 64'd1;
        sticky  = |(x & lo_mask);
        inc     = x[63] ? (guard & sticky) : guard;
        return t + {63'd0, inc};
    endfunction

    // Clamp x to the signed range of a w-bit value; sat flags a clamp.
    function automatic logic signed [63:0] dsp_sat(
        input  logic signed [63:0] x,
        input  int unsigned        w,
        output logic               sat
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        r   = x;
        sat = 1'b0;
        if (x > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (x < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_fifo2.sv
// Two-entry valid/ready output buffer; pop is taken before push so a full buffer can still accept on a pop cycle.
module dsp_fifo2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          drop,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pop;
    logic               do_push;

    always_comb begin
        pop     = (cnt_q != 2'd0) && out_ready;
        do_push = push && ((cnt_q != 2'd2) || pop);
        drop    = push && (cnt_q == 2'd2) && !pop;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = push_data;
        wr_d    = wr_q ^ do_push;
        rd_d    = rd_q ^ pop;
        cnt_d   = cnt_q + 2'(do_push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];

endmodule

// File: rtl/dsp_iq_dump.sv
// I/Q integrate-and-dump decimator with rounded, saturated output into a 2-entry buffer.
// Optional DSP_IQ_DUMP_OVF_CNT_EN adds a saturating 16-bit count of dropped dumps (ovf_cnt).
module dsp_iq_dump
    import dsp_pkg::*;
#(
    parameter int I_W   = 16,
    parameter int ACC_W = 32,
    parameter int O_W   = 16,
    parameter int N_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic signed [I_W-1:0]  i_in,
    input  logic signed [I_W-1:0]  q_in,
    input  logic [N_W-1:0]         dec_m1,
    input  logic [DSP_SHIFT_W-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [O_W-1:0]  i_out,
    output logic signed [O_W-1:0]  q_out,
`ifdef DSP_IQ_DUMP_OVF_CNT_EN
    output logic [15:0]            ovf_cnt,
`endif
    output logic                   ovf,
    output logic                   sat
);

    if (ACC_W < I_W + N_W) begin : g_acc_w_chk
        $error("dsp_iq_dump: ACC_W must be >= I_W + N_W");
    end
    if (ACC_W > 64) begin : g_acc_w_max
        $error("dsp_iq_dump: ACC_W above 64 not supported");
    end

    localparam logic [DSP_SHIFT_W-1:0] SH_MAX = DSP_SHIFT_W'(ACC_W - O_W);

    iq_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
    logic                    dump_vld_q, dump_vld_d;
    logic [N_W-1:0]          cnt_q, cnt_d;
    logic [N_W-1:0]          dec_q, dec_d;
    logic                    ovf_q, ovf_d;
    logic                    sat_q, sat_d;

    logic signed [ACC_W-1:0] s_i, s_q;
    logic [DSP_SHIFT_W-1:0]  sh_eff;
    logic signed [63:0]      r_i, r_q, c_i, c_q;
    logic                    sat_i, sat_qc;
    logic [2*O_W-1:0]        push_data, head;
    logic                    fifo_drop;

    assign s_i = ACC_W'(i_in);
    assign s_q = ACC_W'(q_in);

    // cnt_q holds samples already accumulated in the open window.
    always_comb begin
        state_d    = state_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        cnt_d      = cnt_q;
        dec_d      = dec_q;
        dump_i_d   = dump_i_q;
        dump_q_d   = dump_q_q;
        dump_vld_d = 1'b0;
        if (!en) begin
            state_d = IQ_IDLE;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                IQ_IDLE: begin
                    dec_d = dec_m1;
                    if (dec_m1 == '0) begin
                        dump_i_d   = s_i;
                        dump_q_d   = s_q;
                        dump_vld_d = 1'b1;
                    end else begin
                        acc_i_d = s_i;
                        acc_q_d = s_q;
                        cnt_d   = N_W'(1);
                        state_d = IQ_ACC;
                    end
                end
                default: begin
                    if (cnt_q == dec_q) begin
                        dump_i_d   = acc_i_q + s_i;
                        dump_q_d   = acc_q_q + s_q;
                        dump_vld_d = 1'b1;
                        acc_i_d    = '0;
                        acc_q_d    = '0;
                        cnt_d      = '0;
                        state_d    = IQ_IDLE;
                    end else begin
                        acc_i_d = acc_i_q + s_i;
                        acc_q_d = acc_q_q + s_q;
                        cnt_d   = cnt_q + N_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        sh_eff    = (shift > SH_MAX) ? SH_MAX : shift;
        r_i       = dsp_round_haz(64'(dump_i_q), sh_eff);
        r_q       = dsp_round_haz(64'(dump_q_q), sh_eff);
        c_i       = dsp_sat(r_i, O_W, sat_i);
        c_q       = dsp_sat(r_q, O_W, sat_qc);
        push_data = {O_W'(c_i), O_W'(c_q)};
        sat_d     = dump_vld_q && (sat_i || sat_qc);
        ovf_d     = fifo_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IQ_IDLE;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            cnt_q      <= '0;
            dec_q      <= '0;
            dump_i_q   <= '0;
            dump_q_q   <= '0;
            dump_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            dump_i_q   <= dump_i_d;
            dump_q_q   <= dump_q_d;
            dump_vld_q <= dump_vld_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
        end
    end

    dsp_fifo2 #(.DW(2 * O_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (dump_vld_q),
        .push_data (push_data),
        .drop      (fifo_drop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (head)
    );

    assign i_out = head[2*O_W-1:O_W];
    assign q_out = head[O_W-1:0];
    assign ovf   = ovf_q;
    assign sat   = sat_q;

`ifdef DSP_IQ_DUMP_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (fifo_drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_iq_dump.sv
// Directed bench for dsp_iq_dump: inputs driven and outputs checked on the falling edge.
module tb_dsp_iq_dump;

    logic               clk;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic [7:0]         dec_m1;
    logic [5:0]         shift;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               ovf;
    logic               sat;
`ifdef DSP_IQ_DUMP_OVF_CNT_EN
    logic [15:0]        ovf_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dsp_iq_dump dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .i_in      (i_in),
        .q_in      (q_in),
        .dec_m1    (dec_m1),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .i_out     (i_out),
        .q_out     (q_out),
`ifdef DSP_IQ_DUMP_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .ovf       (ovf),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input int ei, input int eq);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({tag, "_i"}, 32'(i_out), ei);
            chk({tag, "_q"}, 32'(q_out), eq);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; i_in = '0; q_in = '0;
        dec_m1 = 8'd0; shift = 6'd0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_i",     32'(i_out), 0);
        chk("rst_q",     32'(q_out), 0);
        chk("rst_ovf",   32'(ovf), 0);
        chk("rst_sat",   32'(sat), 0);
        rst = 1'b0;

        // N=4 windows back to back: dumps after samples 4 and 8 appear two cycles later
        dec_m1 = 8'd3; shift = 6'd0; i_in = 16'sd1000; q_in = -16'sd1000;
        for (int k = 1; k <= 12; k++) begin
            in_valid = (k <= 8);
            tick();
            chk_out($sformatf("n4_k%0d", k), (k == 5 || k == 9), 4000, -4000);
        end
        in_valid = 1'b0;

        // N=1, shift=1: half-way values round away from zero
        dec_m1 = 8'd0; shift = 6'd1;
        in_valid = 1'b1; i_in = 16'sd3; q_in = -16'sd5;
        tick();
        i_in = -16'sd3;
        tick();
        in_valid = 1'b0;
        chk_out("rnd_a", 1'b1, 2, -3);
        tick();
        chk_out("rnd_b", 1'b1, -2, -3);
        tick();
        chk("rnd_empty", 32'(out_valid), 0);

        // N=256 of full-scale: saturates at shift 0, exact at shift 8
        for (int pass = 0; pass < 2; pass++) begin
            dec_m1 = 8'd255; shift = (pass == 0) ? 6'd0 : 6'd8;
            i_in = 16'sd32767; q_in = 16'sd0; in_valid = 1'b1;
            for (int k = 0; k < 256; k++) tick();
            in_valid = 1'b0;
            tick();
            chk_out($sformatf("big%0d", pass), 1'b1, 32767, 0);
            chk($sformatf("big%0d_sat", pass), 32'(sat), (pass == 0) ? 1 : 0);
            tick();
            chk($sformatf("big%0d_sat_clr", pass), 32'(sat), 0);
        end

        // Stalled consumer: third dump dropped with ovf, first two kept in order
        dec_m1 = 8'd0; shift = 6'd0; out_ready = 1'b0; in_valid = 1'b1;
        i_in = 16'sd10; q_in = -16'sd10; tick();
        i_in = 16'sd20; q_in = -16'sd20; tick();
        i_in = 16'sd30; q_in = -16'sd30; tick();
        in_valid = 1'b0;
        tick();
        chk("drop_ovf", 32'(ovf), 1);
        chk_out("drop_h0", 1'b1, 10, -10);
        tick();
        chk("drop_ovf_clr", 32'(ovf), 0);
        chk_out("drop_hold", 1'b1, 10, -10);
        out_ready = 1'b1;
        tick();
        chk_out("drop_h1", 1'b1, 20, -20);
        tick();
        chk("drop_empty", 32'(out_valid), 0);

        // Ready rises on the cycle of the third push: pop-then-push, nothing lost
        out_ready = 1'b0; in_valid = 1'b1;
        i_in = 16'sd40; q_in = 16'sd4; tick();
        i_in = 16'sd50; q_in = 16'sd5; tick();
        i_in = 16'sd60; q_in = 16'sd6; tick();
        in_valid = 1'b0;
        chk_out("pp_h0", 1'b1, 40, 4);
        out_ready = 1'b1;
        tick();
        chk("pp_ovf", 32'(ovf), 0);
        chk_out("pp_h1", 1'b1, 50, 5);
        tick();
        chk_out("pp_h2", 1'b1, 60, 6);
        tick();
        chk("pp_empty", 32'(out_valid), 0);

        // en dropped after 2 of 4 samples clears the partial window
        dec_m1 = 8'd3; in_valid = 1'b1; i_in = 16'sd1000; q_in = 16'sd1000;
        tick(); tick();
        en = 1'b0; in_valid = 1'b0;
        tick();
        en = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_in = 16'(k); q_in = -16'(k);
            tick();
            chk($sformatf("en_k%0d_valid", k), 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        tick();
        chk_out("en_dump", 1'b1, 10, -10);
        tick();

        // Reset with a held output and a partial window open
        out_ready = 1'b0; dec_m1 = 8'd0; in_valid = 1'b1; i_in = 16'sd7; q_in = 16'sd7;
        tick();
        dec_m1 = 8'd3; i_in = 16'sd500; q_in = 16'sd500;
        tick(); tick();
        in_valid = 1'b0;
        chk_out("pre_rst", 1'b1, 7, 7);
        rst = 1'b1;
        tick();
        chk("rst2_valid", 32'(out_valid), 0);
        chk("rst2_i",     32'(i_out), 0);
        chk("rst2_q",     32'(q_out), 0);
        chk("rst2_ovf",   32'(ovf), 0);
        chk("rst2_sat",   32'(sat), 0);
        rst = 1'b0; out_ready = 1'b1; dec_m1 = 8'd1; in_valid = 1'b1;
        i_in = 16'sd5; q_in = 16'sd1; tick();
        i_in = 16'sd6; q_in = 16'sd2; tick();
        in_valid = 1'b0;
        tick();
        chk_out("post_rst", 1'b1, 11, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
